// File: rtl/sim_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sim_ctrl_pkg
// Shared constants for the simulation / bring-up run controller.
//   - FSM state encoding: ST_HOLD, ST_RUN, ST_DONE
//   - Exit-cause codes reported on sim_run_ctrl.exit_code
// No ports (package).
// ---------------------------------------------------------------------------
package sim_ctrl_pkg;

    typedef logic [1:0] state_t;
    typedef logic [1:0] exit_code_t;

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] EXIT_NONE    = 2'd0;
    localparam logic [1:0] EXIT_HALT    = 2'd1;
    localparam logic [1:0] EXIT_TIMEOUT = 2'd2;
    localparam logic [1:0] EXIT_STALL   = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter: counts up by one while en is high and sticks at
// all-ones instead of wrapping.
// Parameters:
//   WIDTH  counter width
// Ports:
//   clk  in   1      clock
//   rst  in   1      synchronous active-high reset (clears to 0)
//   clr  in   1      synchronous clear, takes priority over en
//   en   in   1      count enable
//   q    out  WIDTH  current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/sim_run_ctrl.sv
// ---------------------------------------------------------------------------
// sim_run_ctrl
// Cycle-accurate run controller for MIPS32 core simulation / FPGA bring-up.
// Holds the core in reset for RST_CYCLES after rst, then runs it until a
// software halt, a cycle timeout or a PC stall (dead loop) ends the run, and
// reports which of those happened.
//
// Optional feature macro: SIM_RUN_CTRL_RETIRE_CNT_EN
//   defined   -> retire_cnt counts RUN cycles with pc_valid (saturating)
//   undefined -> retire_cnt is tied to 0, no counter flops
//
// Ports:
//   clk         in   1      system clock
//   rst         in   1      synchronous active-high reset
//   pc          in   PC_W   core fetch PC
//   pc_valid    in   1      pc qualifies a retired instruction this cycle
//   halt_req    in   1      software halt request (level)
//   core_rst    out  1      synchronous reset to the core (high in HOLD)
//   running     out  1      high in RUN
//   done        out  1      high once the run has ended (sticky until rst)
//   exit_code   out  2      0=none 1=halt 2=timeout 3=stall
//   cycle_cnt   out  CNT_W  cycles spent in RUN, including the exit cycle
//   retire_cnt  out  CNT_W  retired-instruction count (see macro above)
// All outputs come straight from flops or decode of the state register.
// ---------------------------------------------------------------------------
module sim_run_ctrl
    import sim_ctrl_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int CNT_W        = 32,
    parameter int RST_CYCLES   = 4,
    parameter int MAX_CYCLES   = 100,
    parameter int STALL_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  pc,
    input  logic             pc_valid,
    input  logic             halt_req,
    output logic             core_rst,
    output logic             running,
    output logic             done,
    output logic [1:0]       exit_code,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int HOLD_W  = $clog2(RST_CYCLES + 1);
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);

    state_t            state_q, state_d;
    exit_code_t        exit_code_q, exit_code_d;
    logic [PC_W-1:0]   last_pc_q, last_pc_d;
    // Marks that last_pc holds a real PC, so the first valid PC of a run can
    // never match the reset value of last_pc and be mistaken for a stall.
    logic              pc_seen_q, pc_seen_d;

    logic [HOLD_W-1:0]  hold_cnt;
    logic [STALL_W-1:0] stall_cnt;

    logic in_hold;
    logic in_run;
    logic hold_last;
    logic pc_same;
    logic stall_cyc;
    logic pc_load;
    logic timeout_hit;
    logic stall_hit;

    assign in_hold   = (state_q == ST_HOLD);
    assign in_run    = (state_q == ST_RUN);
    assign hold_last = (hold_cnt == HOLD_W'(RST_CYCLES - 1));

    assign pc_same   = pc_seen_q && (pc == last_pc_q);
    assign stall_cyc = in_run && pc_valid && pc_same;
    assign pc_load   = in_run && pc_valid && !pc_same;

    assign timeout_hit = (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
    // stall_cnt counts earlier stall cycles of the current PC; this stall
    // cycle brings it to STALL_CYCLES-1, i.e. STALL_CYCLES valid cycles at
    // one PC including the cycle that first loaded it.
    assign stall_hit   = stall_cyc && (stall_cnt == STALL_W'(STALL_CYCLES - 2));

    sat_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (in_hold),
        .q   (hold_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (in_run),
        .q   (cycle_cnt)
    );

    sat_counter #(.WIDTH(STALL_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (pc_load),
        .en  (stall_cyc),
        .q   (stall_cnt)
    );

`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
    sat_counter #(.WIDTH(CNT_W)) u_retire_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (in_run && pc_valid),
        .q   (retire_cnt)
    );
`else
    assign retire_cnt = '0;
`endif

    always_comb begin
        state_d     = state_q;
        exit_code_d = exit_code_q;
        case (state_q)
            ST_HOLD: begin
                if (hold_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // First match wins: halt, then timeout, then stall.
                if (halt_req) begin
                    state_d     = ST_DONE;
                    exit_code_d = EXIT_HALT;
                end else if (timeout_hit) begin
                    state_d     = ST_DONE;
                    exit_code_d = EXIT_TIMEOUT;
                end else if (stall_hit) begin
                    state_d     = ST_DONE;
                    exit_code_d = EXIT_STALL;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase
    end

    assign last_pc_d = pc_load ? pc : last_pc_q;
    assign pc_seen_d = pc_seen_q | pc_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HOLD;
            exit_code_q <= EXIT_NONE;
            last_pc_q   <= '0;
            pc_seen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            exit_code_q <= exit_code_d;
            last_pc_q   <= last_pc_d;
            pc_seen_q   <= pc_seen_d;
        end
    end

    assign core_rst  = in_hold;
    assign running   = in_run;
    assign done      = (state_q == ST_DONE);
    assign exit_code = exit_code_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
module tb_sim_run_ctrl;

    localparam int PC_W         = 32;
    localparam int CNT_W        = 32;
    localparam int RST_CYCLES   = 4;
    localparam int MAX_CYCLES   = 100;
    localparam int STALL_CYCLES = 16;
    localparam logic [31:0] STALL_PC = 32'h0040_0010;

    logic             clk;
    logic             rst;
    logic [PC_W-1:0]  pc;
    logic             pc_valid;
    logic             halt_req;
    logic             core_rst;
    logic             running;
    logic             done;
    logic [1:0]       exit_code;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retire_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    sim_run_ctrl #(
        .PC_W         (PC_W),
        .CNT_W        (CNT_W),
        .RST_CYCLES   (RST_CYCLES),
        .MAX_CYCLES   (MAX_CYCLES),
        .STALL_CYCLES (STALL_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .halt_req   (halt_req),
        .core_rst   (core_rst),
        .running    (running),
        .done       (done),
        .exit_code  (exit_code),
        .cycle_cnt  (cycle_cnt),
        .retire_cnt (retire_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Behavioural model: tracks the run in terms of "how many hold cycles
    // elapsed", "how many run cycles elapsed", and "how many consecutive
    // valid cycles have shown the same PC".
    // ------------------------------------------------------------------
    int          m_hold;
    bit          m_run;
    bit          m_done;
    int          m_code;
    longint      m_cyc;
    longint      m_ret;
    logic [31:0] m_last;
    bit          m_have;
    int          m_same;

    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    task automatic model_step();
        int code;
        bit stall_now;
        if (rst) begin
            m_hold = 0; m_run = 0; m_done = 0; m_code = 0;
            m_cyc = 0; m_ret = 0; m_last = '0; m_have = 0; m_same = 0;
        end else if (m_done) begin
            // frozen until rst
        end else if (!m_run) begin
            m_hold++;
            if (m_hold == RST_CYCLES) m_run = 1;
        end else begin
            if (m_cyc < CNT_MAX) m_cyc++;
            stall_now = 0;
            if (pc_valid) begin
`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
                if (m_ret < CNT_MAX) m_ret++;
`endif
                if (m_have && pc == m_last) begin
                    m_same++;
                    stall_now = 1;
                end else begin
                    m_same = 1;
                    m_last = pc;
                    m_have = 1;
                end
            end
            code = 0;
            if (halt_req) code = 1;
            else if (m_cyc == MAX_CYCLES) code = 2;
            else if (stall_now && m_same == STALL_CYCLES) code = 3;
            if (code != 0) begin
                m_code = code;
                m_done = 1;
                m_run  = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("core_rst",   64'(core_rst),   64'(!m_run && !m_done));
                chk("running",    64'(running),    64'(m_run));
                chk("done",       64'(done),       64'(m_done));
                chk("exit_code",  64'(exit_code),  64'(m_code));
                chk("cycle_cnt",  64'(cycle_cnt),  64'(m_cyc));
                chk("retire_cnt", 64'(retire_cnt), 64'(m_ret));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reset for 3 cycles, release, and measure how long core_rst stays high.
    task automatic reset_and_start();
        int cnt;
        rst = 1'b1; pc_valid = 1'b0; halt_req = 1'b0; pc = '0;
        repeat (3) @(negedge clk);
        chk_en = 1;
        rst = 1'b0;
        cnt = 0;
        while (core_rst === 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("hold_len", 64'(cnt), 64'(RST_CYCLES));
        chk("run_on_release", 64'(running), 64'd1);
    endtask

    // mode 0: PC +4 every cycle, valid always
    // mode 1: fixed PC, valid always
    // mode 2: fixed PC, valid every other cycle
    // mode 3: PC +4, valid on every third cycle for the first 30 cycles
    // mode 4: random PC repeats / valid / rare halt
    task automatic run_episode(input int mode, input int halt_at, input int rst_at, input int budget);
        int rc;
        int n;
        logic [31:0] pc_r;
        rc = 0; n = 0; pc_r = 32'h0000_2000;
        while (done !== 1'b1 && n < budget) begin
            if (rc == rst_at) begin
                rst = 1'b1; pc_valid = 1'b0; halt_req = 1'b0;
                @(negedge clk);
                chk("midrst_core_rst",  64'(core_rst),   64'd1);
                chk("midrst_running",   64'(running),    64'd0);
                chk("midrst_done",      64'(done),       64'd0);
                chk("midrst_exit_code", 64'(exit_code),  64'd0);
                chk("midrst_cycle_cnt", 64'(cycle_cnt),  64'd0);
                chk("midrst_retire",    64'(retire_cnt), 64'd0);
                return;
            end
            case (mode)
                0: begin pc = 32'(32'h0000_1000 + 4 * rc); pc_valid = 1'b1; end
                1: begin pc = STALL_PC; pc_valid = 1'b1; end
                2: begin pc = STALL_PC; pc_valid = ((rc % 2) == 0); end
                3: begin pc = 32'(32'h0000_1000 + 4 * rc); pc_valid = ((rc % 3) == 0) && (rc < 30); end
                default: begin
                    if ($urandom_range(0, 9) == 0) pc_r = pc_r + 32'd4;
                    pc = pc_r;
                    pc_valid = ($urandom_range(0, 3) != 0);
                end
            endcase
            halt_req = (rc == halt_at) || (mode == 4 && $urandom_range(0, 149) == 0);
            @(negedge clk);
            n++;
            rc++;
        end
        chk("episode_done", 64'(done), 64'd1);
        pc_valid = 1'b0;
        halt_req = 1'b0;
    endtask

    // Random inputs while DONE; the model keeps everything frozen.
    task automatic freeze(input int cycles);
        repeat (cycles) begin
            pc = $urandom;
            pc_valid = $urandom_range(0, 1) == 1;
            halt_req = $urandom_range(0, 1) == 1;
            @(negedge clk);
        end
        pc_valid = 1'b0;
        halt_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pc = '0; pc_valid = 1'b0; halt_req = 1'b0;
        @(negedge clk);

        // Halt at run cycle 20
        reset_and_start();
        run_episode(0, 20, -1, 200);
        chk("halt_code", 64'(exit_code), 64'd1);
        chk("halt_cyc",  64'(cycle_cnt), 64'd21);
        freeze(5);
        chk("halt_frozen_cyc",  64'(cycle_cnt), 64'd21);
        chk("halt_frozen_code", 64'(exit_code), 64'd1);
        chk("halt_core_rst",    64'(core_rst),  64'd0);

        // Timeout
        reset_and_start();
        run_episode(0, -1, -1, 200);
        chk("timeout_code", 64'(exit_code), 64'd2);
        chk("timeout_cyc",  64'(cycle_cnt), 64'd100);

        // Stall, pc_valid every cycle
        reset_and_start();
        run_episode(1, -1, -1, 200);
        chk("stall_code", 64'(exit_code), 64'd3);
        chk("stall_cyc",  64'(cycle_cnt), 64'd16);

        // Stall, pc_valid every other cycle
        reset_and_start();
        run_episode(2, -1, -1, 200);
        chk("stall_alt_code", 64'(exit_code), 64'd3);
        chk("stall_alt_cyc",  64'(cycle_cnt), 64'd31);

        // Halt on the timeout cycle wins
        reset_and_start();
        run_episode(0, 99, -1, 200);
        chk("prio_code", 64'(exit_code), 64'd1);
        chk("prio_cyc",  64'(cycle_cnt), 64'd100);

        // Retire count: 10 valid cycles out of 30, then halt
        reset_and_start();
        run_episode(3, 30, -1, 200);
        chk("retire_code", 64'(exit_code), 64'd1);
        chk("retire_cyc",  64'(cycle_cnt), 64'd31);
`ifdef SIM_RUN_CTRL_RETIRE_CNT_EN
        chk("retire_cnt", 64'(retire_cnt), 64'd10);
`else
        chk("retire_cnt", 64'(retire_cnt), 64'd0);
`endif

        // rst mid-run, then a fresh run
        reset_and_start();
        run_episode(0, -1, 10, 200);
        reset_and_start();
        run_episode(4, -1, 25, 200);

        // Randomized runs
        repeat (12) begin
            reset_and_start();
            run_episode(4, -1, -1, 200);
            freeze(3);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
